// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state/mode enums, register addresses, CTRL bit positions and the event priority helper for led_seq_ctrl
package led_seq_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    OVR_ON  = 3'd2,
    OVR_OFF = 3'd3
  } state_t;
  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_CHASE  = 2'd2,
    M_BOUNCE = 2'd3
  } mode_t;
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_CLR  = 3;
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest_set = 3'(i);
  endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: base-tick prescaler (0..PRESCALE-1) and step counter (0..period); ports clk, reset, period, clr (restart step count), tick, step
module led_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] period,
  input  logic        clr,
  output logic        tick,
  output logic        step
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pcnt;
  logic [15:0]   scnt;
  always_comb begin
    tick = pcnt == PW'(PRESCALE - 1);
    step = tick && scnt == period;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      scnt <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      scnt <= clr || step ? '0 : tick ? scnt + 16'd1 : scnt;
    end
  end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: Avalon-MM LED sequencer with hw-event flash override; ports clk, reset, address/chipselect/write_n/writedata/readdata, hw_evt, led_out; LED_PWM_EN adds brightness PWM
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int PRESCALE    = 50000,
  parameter int N_EVT       = 4,
  parameter int FLASH_TICKS = 250,
  parameter int FLASH_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [N_EVT-1:0] hw_evt,
  output logic [7:0]       led_out
);
  logic        enable;
  mode_t       mode;
  logic [7:0]  pattern;
  logic [15:0] period;
  logic [7:0]  sticky;
  logic [2:0]  idx;
  state_t      state, state_nxt;
  logic [15:0] ftick;
  logic [7:0]  flash_cnt;
  logic        blink_on, bdir;
  logic [7:0]  chase, bounce;
  logic        wr, wr_ctrl, wr_pat, wr_per;
  logic        tick, step, evt, ovr, phase_done, last_flash, restart;
  logic [7:0]  evt8, run_led, base, led_nxt, bright;
  logic [31:0] status;
  logic        unused_wd;
  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk(clk),
    .reset(reset),
    .period(period),
    .clr(wr_per),
    .tick(tick),
    .step(step)
  );
`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= 8'd0;
      bright  <= 8'hFF;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr && address == ADDR_STATUS) bright <= writedata[7:0];
    end
  end
`else
  always_comb bright = 8'h00;
`endif
  always_comb begin
    wr         = chipselect && !write_n;
    wr_ctrl    = wr && address == ADDR_CTRL;
    wr_pat     = wr && address == ADDR_PATTERN;
    wr_per     = wr && address == ADDR_PERIOD;
    unused_wd  = ^writedata[31:16];
    evt8       = 8'(hw_evt);
    evt        = |hw_evt;
    ovr        = state == OVR_ON || state == OVR_OFF;
    phase_done = tick && ftick == 16'(FLASH_TICKS - 1);
    last_flash = flash_cnt == 8'(FLASH_COUNT - 1);
    state_nxt  = !ovr ? (evt ? OVR_ON : enable ? RUN : IDLE) :
                 state == OVR_ON ? (phase_done ? OVR_OFF : OVR_ON) :
                 !phase_done ? OVR_OFF : !last_flash ? OVR_ON : enable ? RUN : IDLE;
    restart    = wr_ctrl || wr_pat || (state == IDLE && state_nxt == RUN);
    run_led    = mode == M_STATIC ? pattern :
                 mode == M_BLINK ? (blink_on ? pattern : 8'h00) :
                 mode == M_CHASE ? chase : bounce;
    base       = state == RUN ? run_led : state == OVR_ON ? ~(8'h01 << idx) : 8'h00;
    led_nxt    = base;
`ifdef LED_PWM_EN
    led_nxt    = ovr ? base : base & {8{pwm_cnt < bright}};
`endif
    status     = {bright, 4'h0, sticky, ovr, state, led_out};
    readdata   = address == ADDR_CTRL ? {29'd0, mode, enable} :
                 address == ADDR_PATTERN ? {24'd0, pattern} :
                 address == ADDR_PERIOD ? {16'd0, period} : status;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= 1'b0;
      mode    <= M_STATIC;
      pattern <= 8'h00;
      period  <= 16'h0000;
      sticky  <= 8'h00;
      idx     <= 3'd0;
    end else begin
      if (wr_ctrl) begin
        enable <= writedata[CTRL_EN];
        mode   <= mode_t'(writedata[CTRL_MODE +: 2]);
      end
      if (wr_pat) pattern <= writedata[7:0];
      if (wr_per) period <= writedata[15:0];
      // a same-cycle event survives clr_evt
      sticky <= (wr_ctrl && writedata[CTRL_CLR] ? 8'h00 : sticky) | evt8;
      if (!ovr && evt) idx <= lowest_set(evt8);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      led_out <= 8'h00;
    end else begin
      state   <= state_nxt;
      led_out <= led_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !ovr) begin
      ftick     <= 16'd0;
      flash_cnt <= 8'd0;
    end else if (tick) begin
      ftick <= phase_done ? 16'd0 : ftick + 16'd1;
      if (state == OVR_OFF && phase_done) flash_cnt <= flash_cnt + 8'd1;
    end
  end
  // pattern state only advances in RUN, so an override resumes where it left off
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_on <= 1'b1;
      chase    <= 8'h00;
      bounce   <= 8'h01;
      bdir     <= 1'b0;
    end else if (restart) begin
      blink_on <= 1'b1;
      chase    <= wr_pat ? writedata[7:0] : pattern;
      bounce   <= 8'h01;
      bdir     <= 1'b0;
    end else if (step && state == RUN) begin
      blink_on <= !blink_on;
      chase    <= {chase[6:0], chase[7]};
      bounce   <= bdir ? (bounce == 8'h01 ? 8'h02 : bounce >> 1) :
                         (bounce == 8'h80 ? 8'h40 : bounce << 1);
      bdir     <= bdir ? bounce != 8'h01 : bounce == 8'h80;
    end
  end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed plus random stimulus checked cycle by cycle against a behavioural model of led_seq_ctrl
module tb_led_seq_ctrl;
  localparam int P = 4, NE = 4, FT = 2, FC = 2;
  logic          clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0]    address = 2'd3;
  logic [31:0]   writedata = 32'd0;
  logic [NE-1:0] hw_evt = '0;
  logic [31:0]   readdata;
  logic [7:0]    led_out;
  int total = 0, bad = 0;
  int cyc, m_mode, m_per, m_tsp, m_st, m_ot, m_idx, m_pos, m_bright;
  logic m_en, m_blink, m_down;
  logic [7:0] m_pat, m_sticky, m_chase, m_led;
  led_seq_ctrl #(.PRESCALE(P), .N_EVT(NE), .FLASH_TICKS(FT), .FLASH_COUNT(FC)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .hw_evt(hw_evt),
    .led_out(led_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] exp_read();
    logic [7:0] b;
    b = 8'h00;
`ifdef LED_PWM_EN
    b = 8'(m_bright);
`endif
    case (address)
      2'd0: exp_read = {29'd0, 2'(m_mode), m_en};
      2'd1: exp_read = {24'd0, m_pat};
      2'd2: exp_read = {16'd0, 16'(m_per)};
      default: exp_read = {b, 4'h0, m_sticky, m_st >= 2, 3'(m_st), m_led};
    endcase
  endfunction
  task automatic clk_step();
    logic wr, tick, stp, evt, restart;
    int lo, t;
    logic [7:0] rl, n_led;
    wr = chipselect && !write_n;
    if (reset) begin
      cyc = 0; m_en = 0; m_mode = 0; m_pat = 0; m_per = 0; m_sticky = 0; m_tsp = 0;
      m_st = 0; m_ot = 0; m_idx = 0; m_blink = 1; m_chase = 0; m_pos = 0; m_down = 0;
      m_led = 0; m_bright = 255;
    end else begin
      tick = (cyc % P) == P - 1;
      stp  = tick && (m_tsp % (m_per + 1)) == m_per;
      evt  = hw_evt != 0;
      lo = 0;
      for (int i = NE - 1; i >= 0; i--) if (hw_evt[i]) lo = i;
      rl = m_mode == 0 ? m_pat : m_mode == 1 ? (m_blink ? m_pat : 8'd0) :
           m_mode == 2 ? m_chase : 8'(1 << m_pos);
      n_led = m_st == 1 ? rl : m_st == 2 ? ~(8'd1 << m_idx) : 8'd0;
`ifdef LED_PWM_EN
      if (m_st < 2 && (cyc % 256) >= m_bright) n_led = 8'd0;
`endif
      restart = (wr && address < 2) || (m_st == 0 && !evt && m_en);
      if (restart) begin
        m_blink = 1;
        m_chase = (wr && address == 1) ? writedata[7:0] : m_pat;
        m_pos = 0;
        m_down = 0;
      end else if (stp && m_st == 1) begin
        m_blink = !m_blink;
        m_chase = {m_chase[6:0], m_chase[7]};
        if (!m_down) begin
          if (m_pos == 7) begin m_pos = 6; m_down = 1; end else m_pos++;
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_down = 0; end else m_pos--;
        end
      end
      if (m_st < 2) begin
        if (evt) begin m_idx = lo; m_st = 2; m_ot = 0; end
        else m_st = m_en ? 1 : 0;
      end else begin
        t = m_ot + int'(tick);
        m_ot = t;
        m_st = (t == 2 * FT * FC) ? (m_en ? 1 : 0) : (((t / FT) % 2) != 0 ? 3 : 2);
      end
      m_sticky = ((wr && address == 0 && writedata[3]) ? 8'd0 : m_sticky) | 8'(hw_evt);
      if (wr && address == 2) m_tsp = 0; else if (tick) m_tsp++;
      if (wr && address == 0) begin m_en = writedata[0]; m_mode = int'(writedata[2:1]); end
      if (wr && address == 1) m_pat = writedata[7:0];
      if (wr && address == 2) m_per = int'(writedata[15:0]);
`ifdef LED_PWM_EN
      if (wr && address == 3) m_bright = int'(writedata[7:0]);
`endif
      m_led = n_led;
      cyc++;
    end
    @(posedge clk);
    #1;
    total++;
    assert (led_out === m_led) else begin
      bad++;
      $error("FAIL led_out got=%h exp=%h at cycle %0d", led_out, m_led, cyc);
    end
    total++;
    assert (readdata === exp_read()) else begin
      bad++;
      $error("FAIL readdata[addr %0d] got=%h exp=%h", address, readdata, exp_read());
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    clk_step();
    chipselect = 0; write_n = 1; address = 2'd3;
  endtask
  task automatic pulse(input logic [NE-1:0] e);
    hw_evt = e;
    clk_step();
    hw_evt = '0;
  endtask
  initial begin
    run(2);
    reset = 0;
    run(3);
    wr_reg(2'd1, 32'hA5);
    wr_reg(2'd0, 32'h1);
    run(6);
    wr_reg(2'd1, 32'h81);
    wr_reg(2'd2, 32'h0);
    wr_reg(2'd0, 32'h5);
    run(40);
    wr_reg(2'd2, 32'h1);
    wr_reg(2'd0, 32'h7);
    run(150);
    wr_reg(2'd0, 32'h3);
    run(13);
    pulse(4'b0110);
    run(80);
    wr_reg(2'd0, 32'hB);
    run(4);
    hw_evt = 4'b0001;
    wr_reg(2'd0, 32'hB);
    hw_evt = '0;
    run(4);
    wr_reg(2'd0, 32'h0);
    run(5);
    pulse(4'b1000);
    run(80);
    pulse(4'b0100);
    run(10);
    pulse(4'b0011);
    run(3);
    reset = 1;
    clk_step();
    reset = 0;
    run(4);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      run(2);
    end
    for (int i = 0; i < 1500; i++) begin
      reset = $urandom_range(0, 399) == 0;
      chipselect = $urandom_range(0, 4) == 0;
      write_n = $urandom_range(0, 9) >= 4;
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (address == 2'd2) writedata = writedata & 32'hFFFF_0003;
      if (address == 2'd0 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
      hw_evt = $urandom_range(0, 39) == 0 ? NE'($urandom) : '0;
      clk_step();
    end
    reset = 0; chipselect = 0; write_n = 1; hw_evt = '0;
    run(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
